regfile_bypass_sb: RTL and testbench
====================================

Name: regfile_bypass_sb

Overview:
- Parametrised 2-read/2-write integer register file for the pipelined RISC-V core.
- Write-first bypass on both read ports.
- Per-register busy scoreboard: set at issue, cleared at writeback.
- Registered debug/display port, replacing the flat per-register output bus.
- Sits between decode (reads, issue) and writeback (ALU port A, load port B).

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of registers; power of two, 2..64; register 0 hardwired to zero.
- AW, $clog2(NREG), address width (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- ra1  in  AW  read address 1.
- ra2  in  AW  read address 2.
- rd1  out  XLEN  read data 1 (combinational).
- rd2  out  XLEN  read data 2 (combinational).
- busy1  out  1  scoreboard bit for ra1 (combinational).
- busy2  out  1  scoreboard bit for ra2 (combinational).
- we_a  in  1  write enable, port A (ALU writeback).
- wa_a  in  AW  write address, port A.
- wd_a  in  XLEN  write data, port A.
- we_b  in  1  write enable, port B (load writeback).
- wa_b  in  AW  write address, port B.
- wd_b  in  XLEN  write data, port B.
- iss_v  in  1  issue valid; marks iss_rd pending.
- iss_rd  in  AW  destination of the issued instruction.
- busy_cnt  out  AW+1  number of registers currently busy (registered).
- dbg_addr  in  AW  debug read address.
- dbg_data  out  XLEN  registered contents of dbg_addr, 1-cycle latency.

Behaviour:
- Reset (rst=0, async): all registers 0, all busy bits 0, busy_cnt 0, dbg_data 0. Held for as long as rst is low. Pending writes and issues during reset are discarded.
- Writes: on rising clk, we_a writes wd_a to wa_a and we_b writes wd_b to wa_b.
  - Writes to address 0 are ignored.
  - Same address, both enabled: port B wins, port A is dropped.
- Reads:
  - rd1/rd2 = 0 when the address is 0.
  - Otherwise, if the address matches an enabled same-cycle write, return that write data (B over A).
  - Otherwise return the stored value.
- Scoreboard, per register r != 0, on rising clk:
  - set = iss_v && iss_rd==r; clr = (we_a && wa_a==r) || (we_b && wa_b==r).
  - set has priority over clr (re-issue to the same rd while the older write retires keeps it busy).
  - busy[0] is always 0; iss_rd=0 is ignored.
- busy1/busy2 read the current busy bits, bypassed with the same-cycle clear. If the address matches a clearing write and there is no same-cycle set for that register, report 0. This matches rd1/rd2 returning the written data.
- busy_cnt: registered population count of busy bits after the update; range 0..NREG-1.
- Clear of a non-busy register: legal, no effect on busy, data written normally.
- Set of an already-busy register: stays busy, no counter change.
- dbg_data: registered each clk from the post-write register state (equivalent to reading the array on the next cycle). dbg_addr=0 returns 0.
- No X propagation: reads of never-written registers after reset return 0.

Test Plan:
- Reset, then read all addresses on both ports -> rd1=rd2=0, busy1=busy2=0, busy_cnt=0, dbg_data=0 for every dbg_addr.
- we_a=1, wa_a=5, wd_a=0xDEADBEEF with ra1=5 in the same cycle -> rd1=0xDEADBEEF immediately. After the edge, dbg_addr=5 gives dbg_data=0xDEADBEEF one cycle later.
- Write 0x1234 to x0 via port A and 0x55 to x0 via port B -> rd1 at ra1=0 stays 0 and dbg_data stays 0.
- Same-cycle we_a=we_b=1, wa_a=wa_b=7, wd_a=0x11, wd_b=0x22 -> rd2 at ra2=7 returns 0x22 in-cycle; stored value is 0x22.
- iss_v=1, iss_rd=9 -> busy for reg 9 = 1 and busy_cnt=1 next cycle.
  - Next cycle: we_b=1, wa_b=9 with iss_v=1, iss_rd=9 -> reg 9 stays busy, busy_cnt=1.
  - Next cycle: we_a=1, wa_a=9 alone -> busy1 at ra1=9 reads 0 in-cycle; busy_cnt=0 after the edge.
- Issue regs 3, 4, 6, then assert rst low mid-cycle (asynchronously, between edges) -> all outputs 0 immediately: busy_cnt=0, dbg_data=0, rd1 for reg 3 = 0 and busy1=0.

Source files
------------

// File: rtl/regfile_bypass_sb_if.sv
// Bundle of the decode/writeback/debug signals of the bypassing register file.
// The master modport is the core side; the slave modport is the register file.
interface regfile_bypass_sb_if #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   localparam int AW = $clog2(NREG)
);
   logic [AW-1:0]   ra1;
   logic [AW-1:0]   ra2;
   logic [XLEN-1:0] rd1;
   logic [XLEN-1:0] rd2;
   logic            busy1;
   logic            busy2;
   logic            we_a;
   logic [AW-1:0]   wa_a;
   logic [XLEN-1:0] wd_a;
   logic            we_b;
   logic [AW-1:0]   wa_b;
   logic [XLEN-1:0] wd_b;
   logic            iss_v;
   logic [AW-1:0]   iss_rd;
   logic [AW:0]     busy_cnt;
   logic [AW-1:0]   dbg_addr;
   logic [XLEN-1:0] dbg_data;

   modport master (
      output ra1, ra2, we_a, wa_a, wd_a, we_b, wa_b, wd_b, iss_v, iss_rd, dbg_addr,
      input  rd1, rd2, busy1, busy2, busy_cnt, dbg_data
   );

   modport slave (
      input  ra1, ra2, we_a, wa_a, wd_a, we_b, wa_b, wd_b, iss_v, iss_rd, dbg_addr,
      output rd1, rd2, busy1, busy2, busy_cnt, dbg_data
   );
endinterface

// File: rtl/regfile_bypass_sb.sv
// 2R/2W register file with write-first bypass, per-register busy scoreboard
// and a registered debug read port. Register 0 is hardwired to zero.
module regfile_bypass_sb #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   localparam int AW = $clog2(NREG)
) (
   input logic              clk,
   input logic              rst,
   regfile_bypass_sb_if.slave bus
);

   logic [XLEN-1:0] regs     [NREG];
   logic [XLEN-1:0] regs_nxt [NREG];
   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_nxt;
   logic [NREG-1:0] set_vec;
   logic [NREG-1:0] clr_vec;
   logic [AW:0]     cnt_nxt;
   logic [AW:0]     busy_cnt_q;
   logic [XLEN-1:0] dbg_q;

   // Post-write view of the array; B is applied last so it wins on a collision.
   always_comb begin
      regs_nxt = regs;
      if (bus.we_a) regs_nxt[bus.wa_a] = bus.wd_a;
      if (bus.we_b) regs_nxt[bus.wa_b] = bus.wd_b;
      regs_nxt[0] = '0;
   end

   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (bus.iss_v) set_vec[bus.iss_rd] = 1'b1;
      if (bus.we_a)  clr_vec[bus.wa_a]   = 1'b1;
      if (bus.we_b)  clr_vec[bus.wa_b]   = 1'b1;
      set_vec[0] = 1'b0;
      clr_vec[0] = 1'b0;
   end

   // Set beats clear so a re-issue to a retiring destination stays pending.
   assign busy_nxt = (busy & ~clr_vec) | set_vec;

   always_comb begin
      cnt_nxt = '0;
      for (int i = 0; i < NREG; i++) begin
         cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
         busy       <= '0;
         busy_cnt_q <= '0;
         dbg_q      <= '0;
      end else begin
         regs       <= regs_nxt;
         busy       <= busy_nxt;
         busy_cnt_q <= cnt_nxt;
         dbg_q      <= regs_nxt[bus.dbg_addr];
      end
   end

   assign bus.rd1      = regs_nxt[bus.ra1];
   assign bus.rd2      = regs_nxt[bus.ra2];
   assign bus.busy1    = busy[bus.ra1] & ~(clr_vec[bus.ra1] & ~set_vec[bus.ra1]);
   assign bus.busy2    = busy[bus.ra2] & ~(clr_vec[bus.ra2] & ~set_vec[bus.ra2]);
   assign bus.busy_cnt = busy_cnt_q;
   assign bus.dbg_data = dbg_q;

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Randomised scoreboard bench for regfile_bypass_sb: the driver pushes expected
// responses from an array-based reference model, the monitor pops and compares.
module tb_regfile_bypass_sb;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   regfile_bypass_sb_if #(.XLEN(XLEN), .NREG(NREG)) bus ();

   regfile_bypass_sb #(.XLEN(XLEN), .NREG(NREG)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic            b1;
      logic            b2;
      int              cnt;
      logic [XLEN-1:0] dbg;
   } exp_t;

   exp_t expq[$];
   int total = 0;
   int bad   = 0;

   logic [XLEN-1:0] mem [NREG];
   bit              bsy [NREG];

   logic [AW-1:0]   s_ra1, s_ra2, s_dbg, s_waa, s_wab, s_ird;
   logic [XLEN-1:0] s_wda, s_wdb;
   logic            s_wea, s_web, s_iss;

   function automatic void chk(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
      end
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NREG; i++) begin
         mem[i] = '0;
         bsy[i] = 1'b0;
      end
   endfunction

   function automatic logic [XLEN-1:0] model_rd(logic [AW-1:0] a);
      if (a == 0) return '0;
      if (s_web && s_wab == a) return s_wdb;
      if (s_wea && s_waa == a) return s_wda;
      return mem[a];
   endfunction

   function automatic logic model_busy(logic [AW-1:0] a);
      bit clr, set;
      if (a == 0) return 1'b0;
      clr = (s_wea && s_waa == a) || (s_web && s_wab == a);
      set = s_iss && s_ird == a;
      if (clr && !set) return 1'b0;
      return bsy[a];
   endfunction

   task automatic idle();
      s_wea = 0; s_waa = '0; s_wda = '0;
      s_web = 0; s_wab = '0; s_wdb = '0;
      s_iss = 0; s_ird = '0;
   endtask

   // One clock cycle: drive staged inputs, push expectation, advance model.
   task automatic step();
      exp_t e;
      @(negedge clk);
      #1;
      bus.ra1 = s_ra1; bus.ra2 = s_ra2; bus.dbg_addr = s_dbg;
      bus.we_a = s_wea; bus.wa_a = s_waa; bus.wd_a = s_wda;
      bus.we_b = s_web; bus.wa_b = s_wab; bus.wd_b = s_wdb;
      bus.iss_v = s_iss; bus.iss_rd = s_ird;
      e.rd1 = model_rd(s_ra1);
      e.rd2 = model_rd(s_ra2);
      e.b1  = model_busy(s_ra1);
      e.b2  = model_busy(s_ra2);
      for (int r = 1; r < NREG; r++) begin
         bit clr, set;
         clr = (s_wea && s_waa == r) || (s_web && s_wab == r);
         set = s_iss && s_ird == r;
         if (set) bsy[r] = 1'b1;
         else if (clr) bsy[r] = 1'b0;
      end
      if (s_wea && s_waa != 0) mem[s_waa] = s_wda;
      if (s_web && s_wab != 0) mem[s_wab] = s_wdb;
      e.cnt = 0;
      for (int r = 0; r < NREG; r++) e.cnt += int'(bsy[r]);
      e.dbg = mem[s_dbg];
      expq.push_back(e);
   endtask

   function automatic logic [AW-1:0] raddr();
      if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
      return AW'($urandom_range(0, NREG - 1));
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("rd1", bus.rd1, e.rd1);
            chk("rd2", bus.rd2, e.rd2);
            chk("busy1", XLEN'(bus.busy1), XLEN'(e.b1));
            chk("busy2", XLEN'(bus.busy2), XLEN'(e.b2));
            @(posedge clk);
            #1;
            chk("busy_cnt", XLEN'(bus.busy_cnt), XLEN'(e.cnt));
            chk("dbg_data", bus.dbg_data, e.dbg);
         end
      end
   end

   initial begin : driver
      int wait_cnt;
      model_reset();
      idle();
      s_ra1 = '0; s_ra2 = '0; s_dbg = '0;
      bus.ra1 = '0; bus.ra2 = '0; bus.dbg_addr = '0;
      bus.we_a = 0; bus.wa_a = '0; bus.wd_a = '0;
      bus.we_b = 0; bus.wa_b = '0; bus.wd_b = '0;
      bus.iss_v = 0; bus.iss_rd = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy_cnt", XLEN'(bus.busy_cnt), '0);
      @(negedge clk);
      rst = 1'b1;

      // Every address reads zero after reset.
      for (int i = 0; i < NREG; i++) begin
         s_ra1 = AW'(i); s_ra2 = AW'(NREG - 1 - i); s_dbg = AW'(i);
         step();
      end

      // Write with same-cycle bypass, then debug read of it.
      s_ra1 = 5; s_wea = 1; s_waa = 5; s_wda = 32'hDEADBEEF;
      step();
      idle(); s_dbg = 5;
      step();
      step();

      // Writes to x0 are dropped.
      s_ra1 = 0; s_dbg = 0;
      s_wea = 1; s_waa = 0; s_wda = 32'h1234;
      s_web = 1; s_wab = 0; s_wdb = 32'h55;
      step();
      idle();
      step();

      // Dual write collision: port B wins.
      s_ra2 = 7; s_dbg = 7;
      s_wea = 1; s_waa = 7; s_wda = 32'h11;
      s_web = 1; s_wab = 7; s_wdb = 32'h22;
      step();
      idle();
      step();

      // Scoreboard: issue, re-issue during retire, then retire.
      s_ra1 = 9; s_iss = 1; s_ird = 9;
      step();
      s_web = 1; s_wab = 9; s_wdb = 32'h99;
      step();
      idle(); s_wea = 1; s_waa = 9; s_wda = 32'h77;
      step();
      idle();
      step();

      // Random traffic.
      for (int n = 0; n < 600; n++) begin
         s_ra1 = raddr(); s_ra2 = raddr(); s_dbg = raddr();
         s_wea = ($urandom_range(0, 2) == 0); s_waa = raddr(); s_wda = $urandom;
         s_web = ($urandom_range(0, 2) == 0); s_wab = raddr(); s_wdb = $urandom;
         s_iss = ($urandom_range(0, 1) == 1); s_ird = raddr();
         step();
      end

      // Asynchronous reset between edges.
      idle(); s_wea = 1; s_waa = 3; s_wda = 32'hAAAA5555; s_ra1 = 3; s_dbg = 3;
      step();
      idle(); s_iss = 1; s_ird = 3;
      step();
      s_ird = 4;
      step();
      s_ird = 6;
      step();
      idle();
      step();
      @(negedge clk);
      #1;
      bus.iss_v = 1; bus.iss_rd = 7;
      bus.we_a = 1; bus.wa_a = 8; bus.wd_a = 32'h0BAD_0BAD;
      bus.ra1 = 3; bus.dbg_addr = 3;
      #2;
      rst = 1'b0;
      #1;
      chk("async_busy_cnt", XLEN'(bus.busy_cnt), '0);
      chk("async_dbg_data", bus.dbg_data, '0);
      chk("async_rd1", bus.rd1, '0);
      chk("async_busy1", XLEN'(bus.busy1), '0);
      @(posedge clk);
      #1;
      chk("held_busy_cnt", XLEN'(bus.busy_cnt), '0);
      @(negedge clk);
      #1;
      bus.iss_v = 0; bus.we_a = 0;
      #1;
      rst = 1'b1;
      model_reset();

      // Writes/issues during reset must not have landed.
      idle(); s_ra1 = 3; s_ra2 = 8; s_dbg = 8;
      step();
      s_ra1 = 7; s_ra2 = 6; s_dbg = 3;
      step();
      idle();
      step();

      wait_cnt = 0;
      while (expq.size() > 0 && wait_cnt < 20) begin
         @(negedge clk);
         wait_cnt++;
      end
      if (expq.size() > 0) chk("drain_timeout", XLEN'(expq.size()), '0);
      @(posedge clk);
      #3;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
